// File: rtl/parking_gate_counter.sv
// Parking lot occupancy counter: debounced entry/exit sensors with a saturating count.
// Optional macro FULL_BLINK_EN makes full_led blink at 1 Hz while the lot is full.
module parking_gate_counter #(
    parameter int CAPACITY       = 8,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int CNT_W          = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             entry_evt,
    output logic             exit_evt,
    output logic             reject,
    output logic             full_led
);

    localparam int                DB_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CAP_C   = CNT_W'(CAPACITY);

    // Bit 0 is the entry sensor, bit 1 the exit sensor.
    logic [1:0]      w_raw;
    logic [1:0]      w_rise;
    logic [1:0]      r_meta;
    logic [1:0]      r_sync;
    logic [1:0]      r_stable;
    logic [1:0]      r_stable_d;
    logic [DB_W-1:0] r_db_cnt [2];

    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_entry_evt;
    logic             r_exit_evt;
    logic             r_reject;

    logic [CNT_W-1:0] w_count_next;
    logic             w_entry_evt_next;
    logic             w_exit_evt_next;
    logic             w_reject_next;
    logic             w_full_next;
    logic             w_empty_next;

    assign w_raw  = {exit_sensor, entry_sensor};
    assign w_rise = r_stable & ~r_stable_d;

    // Two-flop synchronisers plus the delayed stable bits for edge detection.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_meta     <= 2'b00;
            r_sync     <= 2'b00;
            r_stable_d <= 2'b00;
        end else begin
            r_meta     <= w_raw;
            r_sync     <= r_meta;
            r_stable_d <= r_stable;
        end
    end

    // Tick-qualified debounce: stable follows sync after DEBOUNCE_TICKS disagreeing ticks.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_stable <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else if (tick_in) begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Resolve rising edges into the next count and event pulses.
    always_comb begin
        w_count_next     = r_count;
        w_entry_evt_next = 1'b0;
        w_exit_evt_next  = 1'b0;
        w_reject_next    = 1'b0;
        case (w_rise)
            2'b11: begin
                w_entry_evt_next = 1'b1;
                w_exit_evt_next  = 1'b1;
            end
            2'b01: begin
                if (r_count == CAP_C) begin
                    w_reject_next = 1'b1;
                end else begin
                    w_count_next     = r_count + CNT_W'(1);
                    w_entry_evt_next = 1'b1;
                end
            end
            2'b10: begin
                if (r_count == CNT_W'(0)) begin
                    w_count_next = r_count;
                end else begin
                    w_count_next    = r_count - CNT_W'(1);
                    w_exit_evt_next = 1'b1;
                end
            end
            default: begin
                w_count_next = r_count;
            end
        endcase
        w_full_next  = (w_count_next == CAP_C);
        w_empty_next = (w_count_next == CNT_W'(0));
    end

    // Occupancy, flags and pulses are all registered together.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_entry_evt <= 1'b0;
            r_exit_evt  <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_full      <= w_full_next;
            r_empty     <= w_empty_next;
            r_entry_evt <= w_entry_evt_next;
            r_exit_evt  <= w_exit_evt_next;
            r_reject    <= w_reject_next;
        end
    end

    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
    assign entry_evt = r_entry_evt;
    assign exit_evt  = r_exit_evt;
    assign reject    = r_reject;

`ifdef FULL_BLINK_EN
    logic [5:0] r_blink_cnt;
    logic       r_full_led;

    // Blink timer restarts lit on entry to full and toggles every 50 ticks.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= 6'd0;
            r_full_led  <= 1'b0;
        end else if (!w_full_next) begin
            r_blink_cnt <= 6'd0;
            r_full_led  <= 1'b0;
        end else if (!r_full) begin
            r_blink_cnt <= 6'd0;
            r_full_led  <= 1'b1;
        end else if (tick_in) begin
            if (r_blink_cnt == 6'd49) begin
                r_blink_cnt <= 6'd0;
                r_full_led  <= ~r_full_led;
            end else begin
                r_blink_cnt <= r_blink_cnt + 6'd1;
            end
        end
    end

    assign full_led = r_full_led;
`else
    assign full_led = r_full;
`endif

endmodule

// File: tb/tb_parking_gate_counter.sv
// Directed bench for parking_gate_counter with a behavioural occupancy model checked every cycle.
module tb_parking_gate_counter;

    localparam int CAP = 8;
    localparam int DEB = 5;

    logic       clk_in;
    logic       rst;
    logic       tick_in;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       entry_evt;
    logic       exit_evt;
    logic       reject;
    logic       full_led;

    int n_checks = 0;
    int n_fail   = 0;
    int n_entry  = 0;
    int n_exit   = 0;
    int n_rej    = 0;
    int n_both   = 0;

    // Model state: ideal sensor path and saturating occupancy.
    int m_count = 0;
    bit m_p1[2];
    bit m_sync[2];
    bit m_stable[2];
    bit m_pend[2];
    int m_run[2];
    bit m_eevt = 1'b0;
    bit m_xevt = 1'b0;
    bit m_rej  = 1'b0;
    bit m_led  = 1'b0;
`ifdef FULL_BLINK_EN
    int m_ft = 0;
`endif

    parking_gate_counter #(.CAPACITY(CAP), .DEBOUNCE_TICKS(DEB), .CNT_W(4)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick_in     (tick_in),
        .entry_sensor(entry_sensor),
        .exit_sensor (exit_sensor),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .entry_evt   (entry_evt),
        .exit_evt    (exit_evt),
        .reject      (reject),
        .full_led    (full_led)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit raw[2];
        bit was_full;
        raw[0] = entry_sensor;
        raw[1] = exit_sensor;
        if (rst) begin
            m_count = 0;
            m_eevt = 1'b0; m_xevt = 1'b0; m_rej = 1'b0; m_led = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_p1[i] = 1'b0; m_sync[i] = 1'b0; m_stable[i] = 1'b0;
                m_pend[i] = 1'b0; m_run[i] = 0;
            end
`ifdef FULL_BLINK_EN
            m_ft = 0;
`endif
        end else begin
            was_full = (m_count == CAP);
            m_eevt = 1'b0; m_xevt = 1'b0; m_rej = 1'b0;
            if (m_pend[0] && m_pend[1]) begin
                m_eevt = 1'b1; m_xevt = 1'b1;
            end else if (m_pend[0]) begin
                if (m_count == CAP) m_rej = 1'b1;
                else begin m_count = m_count + 1; m_eevt = 1'b1; end
            end else if (m_pend[1]) begin
                if (m_count > 0) begin m_count = m_count - 1; m_xevt = 1'b1; end
            end
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 1'b0;
                if (tick_in) begin
                    m_run[i] = (m_sync[i] != m_stable[i]) ? m_run[i] + 1 : 0;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = m_sync[i];
                        m_run[i] = 0;
                        m_pend[i] = m_stable[i];
                    end
                end
                m_sync[i] = m_p1[i];
                m_p1[i] = raw[i];
            end
`ifdef FULL_BLINK_EN
            if (m_count != CAP) m_ft = 0;
            else if (!was_full) m_ft = 0;
            else if (tick_in) m_ft = m_ft + 1;
            m_led = (m_count == CAP) && ((m_ft / 50) % 2 == 0);
`else
            m_led = (m_count == CAP) && (was_full || !was_full);
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in or posedge rst);
            model_step();
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_in);
            chk("count", count, m_count);
            chk("full", full, (m_count == CAP) ? 1 : 0);
            chk("empty", empty, (m_count == 0) ? 1 : 0);
            chk("entry_evt", entry_evt, m_eevt);
            chk("exit_evt", exit_evt, m_xevt);
            chk("reject", reject, m_rej);
            chk("full_led", full_led, m_led);
            if (entry_evt === 1'b1) n_entry++;
            if (exit_evt === 1'b1) n_exit++;
            if (reject === 1'b1) n_rej++;
            if (entry_evt === 1'b1 && exit_evt === 1'b1) n_both++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            step(3);
            tick_in = 1'b1;
            step(1);
            tick_in = 1'b0;
        end
    endtask

    task automatic do_entry();
        entry_sensor = 1'b1;
        do_ticks(6);
        entry_sensor = 1'b0;
        do_ticks(6);
    endtask

    task automatic do_exit();
        exit_sensor = 1'b1;
        do_ticks(6);
        exit_sensor = 1'b0;
        do_ticks(6);
    endtask

    initial begin
        rst = 1'b1;
        tick_in = 1'b0;
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        step(3);
        rst = 1'b0;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pulses", {entry_evt, exit_evt, reject}, 0);
        chk("rst_led", full_led, 0);

        do_entry();
        chk("single_evts", n_entry, 1);
        chk("single_count", count, 1);
        chk("single_empty", empty, 0);

        entry_sensor = 1'b1;
        do_ticks(3);
        entry_sensor = 1'b0;
        do_ticks(6);
        chk("glitch_evts", n_entry, 1);
        chk("glitch_count", count, 1);

        repeat (7) do_entry();
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_evts", n_entry, 8);
        do_entry();
        chk("reject_pulses", n_rej, 1);
        chk("reject_evts", n_entry, 8);
        chk("reject_count", count, 8);
        chk("model_full", m_count, 8);

`ifdef FULL_BLINK_EN
        do_ticks(105);
`endif

        repeat (5) do_exit();
        chk("exit_count", count, 3);
        chk("exit_evts", n_exit, 5);

        entry_sensor = 1'b1;
        exit_sensor = 1'b1;
        do_ticks(6);
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        do_ticks(6);
        chk("simul_both", n_both, 1);
        chk("simul_count", count, 3);
        chk("simul_entry", n_entry, 9);
        chk("simul_exit", n_exit, 6);

        repeat (3) do_exit();
        chk("drain_count", count, 0);
        do_exit();
        chk("under_exits", n_exit, 9);
        chk("under_count", count, 0);
        chk("under_empty", empty, 1);

        tick_in = 1'b1;
        entry_sensor = 1'b1;
        step(10);
        entry_sensor = 1'b0;
        step(10);
        tick_in = 1'b0;
        chk("tickhigh_count", count, 1);
        chk("tickhigh_evts", n_entry, 10);

        entry_sensor = 1'b1;
        do_ticks(3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        do_ticks(2);
        step(4);
        chk("midrst_count", count, 0);
        chk("midrst_evts", n_entry, 10);
        chk("model_midrst", m_count, 0);
        entry_sensor = 1'b0;
        do_ticks(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
